// File: rtl/booth_mac_pkg.sv
// rtl/booth_mac_pkg.sv - shared constants, sizing functions and radix-4 recoder for booth_mac_pipe
package booth_mac_pkg;

    localparam logic [1:0] MODE_MUL  = 2'b00;
    localparam logic [1:0] MODE_MAC  = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_MSUB = 2'b11;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_A    = 2'd1,
        SEL_2A   = 2'd2
    } booth_sel_e;

    typedef struct packed {
        booth_sel_e sel;
        logic       neg;
    } booth_digit_t;

    function automatic int npp(input int w);
        return w / 2 + 1;
    endfunction

    function automatic int tree_depth(input int w);
        return $clog2(npp(w) + 1);
    endfunction

    function automatic int latency(input int w);
        return 4 + tree_depth(w);
    endfunction

    // Operand count entering tree level lvl (level 0 = partial products + correction).
    function automatic int tree_count(input int w, input int lvl);
        int n;
        n = npp(w) + 1;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    function automatic booth_digit_t booth_recode(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b001, 3'b010: d = '{sel: SEL_A,    neg: 1'b0};
            3'b011:         d = '{sel: SEL_2A,   neg: 1'b0};
            3'b100:         d = '{sel: SEL_2A,   neg: 1'b1};
            3'b101, 3'b110: d = '{sel: SEL_A,    neg: 1'b1};
            default:        d = '{sel: SEL_ZERO, neg: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// rtl/booth_pp_sel.sv - registered radix-4 Booth digit selector producing one partial product
module booth_pp_sel
    import booth_mac_pkg::*;
#(
    parameter int PPW = 11
) (
    input  logic           clk,
    input  logic           en,
    input  logic [2:0]     trip,
    input  logic [PPW-1:0] a1,
    input  logic [PPW-1:0] a2,
    output logic [PPW-1:0] pp,
    output logic           neg
);

    booth_digit_t   dig;
    logic [PPW-1:0] mag;

    always_comb begin
        dig = booth_recode(trip);
        case (dig.sel)
            SEL_A:   mag = a1;
            SEL_2A:  mag = a2;
            default: mag = '0;
        endcase
    end

    // Negative digits emit the one's complement; the +1 rides in the correction vector.
    always_ff @(posedge clk) begin
        if (en) begin
            pp  <= dig.neg ? ~mag : mag;
            neg <= dig.neg;
        end
    end

endmodule

// File: rtl/booth_mac_pipe.sv
// rtl/booth_mac_pipe.sv - pipelined radix-4 Booth multiplier with signed accumulator and stall-able handshakes
module booth_mac_pipe
    import booth_mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GUARD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    input  logic [1:0]                sm,
    input  logic [1:0]                mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*WIDTH-1:0]        p,
    output logic [2*WIDTH+GUARD-1:0]  acc,
    output logic                      ovf
);

    localparam int ACC_W = 2 * WIDTH + GUARD;
    localparam int PW    = 2 * WIDTH;
    localparam int PPW   = WIDTH + 3;
    localparam int NPP   = npp(WIDTH);
    localparam int NOPS  = NPP + 1;
    localparam int D     = tree_depth(WIDTH);
    localparam int LAT   = latency(WIDTH);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    // Slot control travels beside the datapath; vld[LAT-1] is the last tree level.
    logic [LAT-1:0] vld;
    logic [LAT-1:0] sx_q;
    logic [1:0]     mode_q [0:LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (adv) begin
            vld <= {vld[LAT-2:0], in_valid && in_ready};
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            mode_q[0] <= mode;
            sx_q[0]   <= |sm;
            for (int s = 1; s < LAT; s++) begin
                mode_q[s] <= mode_q[s-1];
                sx_q[s]   <= sx_q[s-1];
            end
        end
    end

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       sm_r;

    always_ff @(posedge clk) begin
        if (adv) begin
            a_r  <= a;
            b_r  <= b;
            sm_r <= sm;
        end
    end

    logic [WIDTH+1:0] a_ext;
    logic [PPW-1:0]   a1;
    logic [PPW-1:0]   a2;
    logic [PPW-1:0]   bx;

    assign a_ext = {{2{sm_r[1] & a_r[WIDTH-1]}}, a_r};

    // Both operands widened by two bits so unsigned inputs recode as non-negative signed values.
    always_ff @(posedge clk) begin
        if (adv) begin
            a1 <= {a_ext[WIDTH+1], a_ext};
            a2 <= {a_ext, 1'b0};
            bx <= {{2{sm_r[0] & b_r[WIDTH-1]}}, b_r, 1'b0};
        end
    end

    logic [PPW-1:0] pp [0:NPP-1];
    logic [NPP-1:0] neg;

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        booth_pp_sel #(
            .PPW (PPW)
        ) u_sel (
            .clk  (clk),
            .en   (adv),
            .trip (bx[2*i+2:2*i]),
            .a1   (a1),
            .a2   (a2),
            .pp   (pp[i]),
            .neg  (neg[i])
        );
    end

    logic [PW-1:0] lvl [0:D][0:NOPS-1];
    logic [PW-1:0] cor;

    always_comb begin
        cor = '0;
        for (int i = 0; i < NPP; i++) begin
            cor[2*i] = neg[i];
        end
    end

    // All tree arithmetic is modulo 2^PW; the exact product always fits there.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < NPP; i++) begin
                lvl[0][i] <= {{(PW-PPW){pp[i][PPW-1]}}, pp[i]} << (2 * i);
            end
            lvl[0][NPP] <= cor;
        end
    end

    for (genvar l = 1; l <= D; l++) begin : g_lvl
        localparam int N = tree_count(WIDTH, l - 1);
        for (genvar j = 0; j < (N + 1) / 2; j++) begin : g_node
            if (2 * j + 1 < N) begin : g_add
                always_ff @(posedge clk) begin
                    if (adv) begin
                        lvl[l][j] <= lvl[l-1][2*j] + lvl[l-1][2*j+1];
                    end
                end
            end else begin : g_pass
                always_ff @(posedge clk) begin
                    if (adv) begin
                        lvl[l][j] <= lvl[l-1][2*j];
                    end
                end
            end
        end
    end

    logic [PW-1:0]    sum;
    logic [ACC_W-1:0] pe;
    logic [ACC_W-1:0] add_r;
    logic [ACC_W-1:0] sub_r;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum = lvl[D][0];

    always_comb begin
        pe      = sx_q[LAT-1] ? {{GUARD{sum[PW-1]}}, sum} : {{GUARD{1'b0}}, sum};
        add_r   = acc + pe;
        sub_r   = acc - pe;
        add_ovf = (acc[ACC_W-1] == pe[ACC_W-1]) && (add_r[ACC_W-1] != acc[ACC_W-1]);
        sub_ovf = (acc[ACC_W-1] != pe[ACC_W-1]) && (sub_r[ACC_W-1] != acc[ACC_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= vld[LAT-1];
            if (vld[LAT-1]) begin
                p <= sum;
                case (mode_q[LAT-1])
                    MODE_MAC: begin
                        acc <= add_r;
                        ovf <= ovf | add_ovf;
                    end
                    MODE_LOAD: begin
                        acc <= pe;
                        ovf <= 1'b0;
                    end
                    MODE_MSUB: begin
                        acc <= sub_r;
                        ovf <= ovf | sub_ovf;
                    end
                    default: begin
                        acc <= acc;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_booth_mac_pipe.sv
// tb/tb_booth_mac_pipe.sv - directed and randomized self-checking bench for booth_mac_pipe
module tb_booth_mac_pipe;
    import booth_mac_pkg::*;

    localparam int WIDTH = 8;
    localparam int GUARD = 4;
    localparam int LAT   = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  sm;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic [19:0] acc;
    logic        ovf;

    booth_mac_pipe #(
        .WIDTH (WIDTH),
        .GUARD (GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sm        (sm),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .acc       (acc),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] p;
        logic [19:0] acc;
        logic        ovf;
        int          c_in;
        int          st_in;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stalls = 0;
    int          stall_left = 0;
    int          rx = 0;
    bit          accepted;
    longint      acc_m = 0;
    bit          ovf_m = 0;
    logic [15:0] last_p;
    logic [19:0] last_acc;
    logic        last_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint opval(input logic [7:0] v, input logic s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    task automatic model_push(input logic [7:0] ai, input logic [7:0] bi,
                              input logic [1:0] smi, input logic [1:0] modei);
        longint prod;
        longint t;
        exp_t   e;
        prod = opval(ai, smi[1]) * opval(bi, smi[0]);
        t = acc_m;
        case (modei)
            MODE_MAC:  t = acc_m + prod;
            MODE_LOAD: t = prod;
            MODE_MSUB: t = acc_m - prod;
            default:   t = acc_m;
        endcase
        if (modei == MODE_LOAD) ovf_m = 1'b0;
        else if (modei != MODE_MUL && (t > 524287 || t < -524288)) ovf_m = 1'b1;
        t = t & 64'hFFFFF;
        if (t >= 524288) t = t - 1048576;
        acc_m   = t;
        e.p     = prod[15:0];
        e.acc   = acc_m[19:0];
        e.ovf   = ovf_m;
        e.c_in  = cyc;
        e.st_in = stalls;
        q.push_back(e);
    endtask

    task automatic step();
        #1;
        accepted = in_valid && in_ready && !rst;
        if (rst) begin
            chk("in_ready_during_rst", in_ready, 0);
            q.delete();
            acc_m = 0;
            ovf_m = 1'b0;
        end else begin
            if (out_valid) begin
                chk("out_has_item", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("p", p, q[0].p);
                    chk("acc", acc, q[0].acc);
                    chk("ovf", ovf, q[0].ovf);
                    if (out_ready) begin
                        chk("latency", cyc - q[0].c_in - 1 - (stalls - q[0].st_in), LAT);
                        last_p   = p;
                        last_acc = acc;
                        last_ovf = ovf;
                        rx++;
                        void'(q.pop_front());
                    end
                end
                if (!out_ready) begin
                    chk("in_ready_stall", in_ready, 0);
                    stalls++;
                end
            end
            if (accepted) model_push(a, b, sm, mode);
        end
        @(posedge clk);
        cyc++;
        #1;
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
    endtask

    task automatic send(input logic [7:0] ai, input logic [7:0] bi,
                        input logic [1:0] smi, input logic [1:0] modei);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = ai;
        b = bi;
        sm = smi;
        mode = modei;
        do begin
            step();
            n++;
        end while (!accepted && n < 100);
        chk("send_accepted", accepted, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int rx0;
        int st0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sm = '0;
        mode = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p", p, 0);
        chk("rst_acc", acc, 0);
        chk("rst_ovf", ovf, 0);
        chk("in_ready_after_rst", in_ready, 1);

        send(8'h80, 8'h80, 2'b11, MODE_MUL);
        drain();
        chk("p_s80_s80", last_p, 16'h4000);
        send(8'hFF, 8'hFF, 2'b00, MODE_MUL);
        drain();
        chk("p_uFF_uFF", last_p, 16'hFE01);
        send(8'hFF, 8'hFF, 2'b10, MODE_MUL);
        drain();
        chk("p_sFF_uFF", last_p, 16'hFF01);
        send(8'h02, 8'hFF, 2'b01, MODE_MUL);
        drain();
        chk("p_u02_sFF", last_p, 16'hFFFE);

        send(8'd3, 8'd4, 2'b00, MODE_LOAD);
        send(8'd5, 8'd6, 2'b00, MODE_MAC);
        send(8'd2, 8'd2, 2'b00, MODE_MSUB);
        send(8'd7, 8'd7, 2'b00, MODE_MUL);
        drain();
        chk("mac_seq_acc", last_acc, 38);
        chk("mac_seq_p", last_p, 49);

        send(8'h00, 8'h00, 2'b11, MODE_LOAD);
        for (int i = 0; i < 31; i++) send(8'h80, 8'h80, 2'b11, MODE_MAC);
        drain();
        chk("mac31_acc", last_acc, 507904);
        chk("mac31_ovf", last_ovf, 0);
        send(8'h80, 8'h80, 2'b11, MODE_MAC);
        drain();
        chk("mac32_acc", last_acc, 20'h80000);
        chk("mac32_ovf", last_ovf, 1);
        send(8'h01, 8'h01, 2'b11, MODE_LOAD);
        drain();
        chk("load_clears_acc", last_acc, 1);
        chk("load_clears_ovf", last_ovf, 0);

        rx0 = rx;
        st0 = stalls;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) stall_left = 10;
            send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        drain();
        chk("stream_count", rx - rx0, 20);
        chk("stream_stall_cycles", stalls - st0, 10);

        for (int i = 0; i < 5; i++) begin
            send(8'($urandom), 8'($urandom), 2'b11, MODE_MAC);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'd9;
        b = 8'd9;
        sm = 2'b00;
        mode = MODE_MAC;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        rx0 = rx;
        send(8'd3, 8'd5, 2'b11, MODE_MAC);
        drain();
        repeat (10) step();
        chk("post_rst_count", rx - rx0, 1);
        chk("post_rst_acc", last_acc, 15);
        chk("post_rst_p", last_p, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
